video_timing_ctrl: RTL and testbench
====================================

# video_timing_ctrl

Frame-level sequencer for the HDMI TX path. Generates pixel coordinates, sync, active-video, and new-frame strobes for the pixel pipeline, and drives the `ve_in`/`control_in` inputs of the three per-channel TMDS encoders. Start and stop requests take effect only on frame boundaries, so the link never emits a partial frame.

## Interface
Parameters (defaults are 1280x720@60):
- ACTIVE_H, 1280, active pixels per line
- H_FP, 110, horizontal front porch
- H_SYNC, 40, hsync width
- H_BP, 220, horizontal back porch (H_TOTAL = 1650)
- ACTIVE_V, 720, active lines
- V_FP, 5, vertical front porch
- V_SYNC, 5, vsync width
- V_BP, 20, vertical back porch (V_TOTAL = 750)
- HS_POL, 1, asserted level of hs_out
- VS_POL, 1, asserted level of vs_out
- FPS, 60, frame counter modulus

Ports:
- clk_in  in  1  pixel clock; one clock domain; all logic on posedge
- rst_in  in  1  synchronous, active-high reset
- en_in  in  1  run request (level)
- hcount_out  out  11  horizontal position, 0..H_TOTAL-1
- vcount_out  out  10  vertical position, 0..V_TOTAL-1
- hs_out  out  1  horizontal sync at HS_POL
- vs_out  out  1  vertical sync at VS_POL
- ad_out  out  1  active-display flag
- nf_out  out  1  one-cycle new-frame strobe
- fc_out  out  6  frame count, 0..FPS-1
- ve_out  out  1  to encoder ve_in; equals ad_out
- ctrl_out  out  2  to blue encoder control_in; equals {vs_out, hs_out}; red and green encoders tie control_in to 0
- running_out  out  1  high while the state is RUN or DRAIN

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - counters hold at 0; ad_out=0; hs_out/vs_out at their inactive levels; nf_out=0.
  - If en_in=1, move to RUN. The next cycle presents pixel (0,0) with ad_out=1.
- RUN:
  - hcount increments each cycle and wraps from H_TOTAL-1 to 0.
  - vcount increments on each hcount wrap and wraps from V_TOTAL-1 to 0.
  - If en_in=0, move to DRAIN. Counting continues unchanged.
- DRAIN:
  - Counting continues. If en_in=1 again, return to RUN with no discontinuity.
  - At (H_TOTAL-1, V_TOTAL-1) with en_in=0, move to IDLE. The next cycle shows counters 0 and ad_out=0.
- In RUN, if en_in drops exactly on (H_TOTAL-1, V_TOTAL-1), go directly to IDLE.
- Decode (combinational on the next counter values, then registered; all outputs describe the same pixel in the same cycle):
  - ad = hcount<ACTIVE_H && vcount<ACTIVE_V
  - hs asserted for hcount in [ACTIVE_H+H_FP, ACTIVE_H+H_FP+H_SYNC-1], i.e. 1390..1429
  - vs asserted for vcount in [ACTIVE_V+V_FP, ACTIVE_V+V_FP+V_SYNC-1], i.e. 725..729, for the whole line
- nf_out: high for exactly one cycle when (hcount,vcount) = (0, ACTIVE_V), the start of vertical blanking.
- fc_out: increments in the same cycle as nf_out and wraps from FPS-1 to 0. It holds its value in IDLE and is not cleared by stop/start.
- Counter arithmetic is unsigned. Widths are fixed by the ports; parameter sets whose totals exceed 2048/1024 are unsupported.

## Timing
- Reset values: state=IDLE; hcount_out=0; vcount_out=0; ad_out=0; ve_out=0; nf_out=0; fc_out=0; running_out=0; hs_out=~HS_POL; vs_out=~VS_POL; ctrl_out={~VS_POL,~HS_POL}.
- All outputs are registered. Latency from en_in rising in IDLE to the first active pixel is 1 cycle.
- rst_in mid-frame: the next cycle shows the reset values, regardless of en_in. en_in sampled in the cycle after rst_in deasserts starts a fresh frame.
- The TMDS encoders add 1 cycle. The pixel source must present data for (hcount_out, vcount_out) in the same cycle those values appear, so RGB, ve, and ctrl reach the encoders together.
- Frame period: H_TOTAL*V_TOTAL = 1,237,500 cycles. No cycle is dropped or repeated at line or frame wrap.

## Structure
- Package video_timing_pkg holds:
  - the FSM state typedef (IDLE, RUN, DRAIN)
  - 720p timing localparams
  - width constants for H and V
- Sub-module wrap_counter: parameterised MAX, with inc and clear inputs, and value and wrap outputs. Instantiate it twice (h and v); the h wrap output drives the v inc input.

## Test plan
- Reset, then en_in=1 for one cycle only: after 1 cycle, (0,0) with ad=1. Running continues through DRAIN to exactly (1649,749), then IDLE with counters 0 and ad=0.
- Continuous en_in=1 over 2 frames: hs high for exactly 40 cycles per line starting at h=1390; vs high for lines 725..729; ad high for 921,600 cycles per frame; nf pulses at (0,720); fc goes 0→1→2.
- en_in drops at (640,300) and rises at (0,500): no state change visible on the counters, running_out stays 1, no gap in the frame.
- rst_in asserted at (1000,400): next cycle shows all reset values and fc_out=0. en_in held high then restarts at (0,0).
- Run 60 frames: fc_out wraps from 59 to 0 at the 60th nf pulse. ctrl_out equals {vs,hs} and ve_out equals ad in every cycle.
- HS_POL=0, VS_POL=0 build: hs/vs idle high in reset and IDLE, and low only inside the sync windows.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared types and constants for the HDMI TX frame timing sequencer.
package video_timing_pkg;

    // Sequencer states: stopped, running, running-until-frame-end.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } vt_state_e;

    // Counter widths fixed by the output ports.
    localparam int H_W  = 11;
    localparam int V_W  = 10;
    localparam int FC_W = 6;

    // 1280x720@60 timing.
    localparam int ACTIVE_H_720P = 1280;
    localparam int H_FP_720P     = 110;
    localparam int H_SYNC_720P   = 40;
    localparam int H_BP_720P     = 220;
    localparam int ACTIVE_V_720P = 720;
    localparam int V_FP_720P     = 5;
    localparam int V_SYNC_720P   = 5;
    localparam int V_BP_720P     = 20;
    localparam int FPS_720P      = 60;

endpackage

// File: rtl/video_timing_ctrl_wrap_counter.sv
// Modulo-(MAX+1) up-counter. Exposes both the registered value and the
// value it will take on the next edge so downstream decode can be
// registered in step with the count.
module wrap_counter
    import video_timing_pkg::*;
#(
    parameter int WIDTH = H_W,
    parameter int MAX   = 1649
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] value_next,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    // Next count: clear wins, then wrap at MAX, else increment when enabled.
    always_comb begin
        wrap    = inc && (value_q == MAX_V);
        value_d = value_q;
        if (clear) begin
            value_d = '0;
        end else if (wrap) begin
            value_d = '0;
        end else if (inc) begin
            value_d = value_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (srst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value      = value_q;
    assign value_next = value_d;

endmodule

// File: rtl/video_timing_ctrl.sv
// Frame-level timing sequencer for the HDMI TX path. Starts and stops only
// on frame boundaries; every output is registered and describes the pixel
// at (hcount_out, vcount_out) in the same cycle.
module video_timing_ctrl
    import video_timing_pkg::*;
#(
    parameter int   ACTIVE_H = ACTIVE_H_720P,
    parameter int   H_FP     = H_FP_720P,
    parameter int   H_SYNC   = H_SYNC_720P,
    parameter int   H_BP     = H_BP_720P,
    parameter int   ACTIVE_V = ACTIVE_V_720P,
    parameter int   V_FP     = V_FP_720P,
    parameter int   V_SYNC   = V_SYNC_720P,
    parameter int   V_BP     = V_BP_720P,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1,
    parameter int   FPS      = FPS_720P
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            en_in,
    output logic [H_W-1:0]  hcount_out,
    output logic [V_W-1:0]  vcount_out,
    output logic            hs_out,
    output logic            vs_out,
    output logic            ad_out,
    output logic            nf_out,
    output logic [FC_W-1:0] fc_out,
    output logic            ve_out,
    output logic [1:0]      ctrl_out,
    output logic            running_out
);

    localparam int H_TOTAL = ACTIVE_H + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = ACTIVE_V + V_FP + V_SYNC + V_BP;

    localparam logic [H_W-1:0]  H_ACT    = H_W'(ACTIVE_H);
    localparam logic [H_W-1:0]  HS_START = H_W'(ACTIVE_H + H_FP);
    localparam logic [H_W-1:0]  HS_END   = H_W'(ACTIVE_H + H_FP + H_SYNC - 1);
    localparam logic [V_W-1:0]  V_ACT    = V_W'(ACTIVE_V);
    localparam logic [V_W-1:0]  VS_START = V_W'(ACTIVE_V + V_FP);
    localparam logic [V_W-1:0]  VS_END   = V_W'(ACTIVE_V + V_FP + V_SYNC - 1);
    localparam logic [FC_W-1:0] FC_MAX   = FC_W'(FPS - 1);

    vt_state_e       state_q, state_d;
    logic [H_W-1:0]  h_value, h_next;
    logic [V_W-1:0]  v_value, v_next;
    logic            h_wrap, v_wrap;
    logic            count_en;
    logic            count_clear;
    logic            live;

    logic            hs_q, hs_d;
    logic            vs_q, vs_d;
    logic            ad_q, ad_d;
    logic            nf_q, nf_d;
    logic [FC_W-1:0] fc_q, fc_d;
    logic            running_q, running_d;

    // Counters advance whenever a frame is in flight; dropping to IDLE
    // forces them to zero.
    assign count_en    = (state_q != IDLE);
    assign count_clear = (state_d == IDLE);

    wrap_counter #(.WIDTH(H_W), .MAX(H_TOTAL - 1)) u_h_counter (
        .clk        (clk_in),
        .srst       (rst_in),
        .inc        (count_en),
        .clear      (count_clear),
        .value      (h_value),
        .value_next (h_next),
        .wrap       (h_wrap)
    );

    wrap_counter #(.WIDTH(V_W), .MAX(V_TOTAL - 1)) u_v_counter (
        .clk        (clk_in),
        .srst       (rst_in),
        .inc        (h_wrap),
        .clear      (count_clear),
        .value      (v_value),
        .value_next (v_next),
        .wrap       (v_wrap)
    );

    // Next-state: start immediately, stop only as the last pixel of a
    // frame is left (v_wrap is only true on that final pixel).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en_in) state_d = RUN;
            RUN:     if (!en_in) state_d = v_wrap ? IDLE : DRAIN;
            DRAIN: begin
                if (en_in) begin
                    state_d = RUN;
                end else if (v_wrap) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Decode the pixel about to be presented so the registered flags line
    // up with the registered counters.
    always_comb begin
        live      = (state_d != IDLE);
        ad_d      = live && (h_next < H_ACT) && (v_next < V_ACT);
        hs_d      = (live && (h_next >= HS_START) && (h_next <= HS_END)) ? HS_POL : ~HS_POL;
        vs_d      = (live && (v_next >= VS_START) && (v_next <= VS_END)) ? VS_POL : ~VS_POL;
        nf_d      = live && (h_next == '0) && (v_next == V_ACT);
        running_d = live;
        fc_d      = fc_q;
        if (nf_d) begin
            fc_d = (fc_q == FC_MAX) ? '0 : fc_q + 1'b1;
        end
    end

    // State and decoded-output registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            hs_q      <= ~HS_POL;
            vs_q      <= ~VS_POL;
            ad_q      <= 1'b0;
            nf_q      <= 1'b0;
            fc_q      <= '0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            ad_q      <= ad_d;
            nf_q      <= nf_d;
            fc_q      <= fc_d;
            running_q <= running_d;
        end
    end

    assign hcount_out  = h_value;
    assign vcount_out  = v_value;
    assign hs_out      = hs_q;
    assign vs_out      = vs_q;
    assign ad_out      = ad_q;
    assign nf_out      = nf_q;
    assign fc_out      = fc_q;
    assign ve_out      = ad_q;
    assign ctrl_out    = {vs_q, hs_q};
    assign running_out = running_q;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Directed bench for video_timing_ctrl using a reduced raster so whole
// frames fit in a short run: 8 active + 2 FP + 3 sync + 3 BP = 16 columns,
// 6 active + 1 FP + 2 sync + 1 BP = 10 lines, 160 cycles per frame.
// hsync columns 10..12, vsync lines 7..8, new frame at (0,6).
// A second instance uses negative sync polarity.
module tb_video_timing_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;

    always #5 clk = ~clk;

    logic [10:0] hc, hc_n;
    logic [9:0]  vc, vc_n;
    logic        hs, vs, ad, nf, ve, run;
    logic        hs_n, vs_n, ad_n, nf_n, ve_n, run_n;
    logic [5:0]  fc, fc_n;
    logic [1:0]  ctrl, ctrl_n;

    video_timing_ctrl #(
        .ACTIVE_H(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .ACTIVE_V(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .FPS(60)
    ) dut (
        .clk_in(clk), .rst_in(rst), .en_in(en),
        .hcount_out(hc), .vcount_out(vc), .hs_out(hs), .vs_out(vs),
        .ad_out(ad), .nf_out(nf), .fc_out(fc), .ve_out(ve),
        .ctrl_out(ctrl), .running_out(run)
    );

    video_timing_ctrl #(
        .ACTIVE_H(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .ACTIVE_V(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .FPS(60)
    ) dut_neg (
        .clk_in(clk), .rst_in(rst), .en_in(en),
        .hcount_out(hc_n), .vcount_out(vc_n), .hs_out(hs_n), .vs_out(vs_n),
        .ad_out(ad_n), .nf_out(nf_n), .fc_out(fc_n), .ve_out(ve_n),
        .ctrl_out(ctrl_n), .running_out(run_n)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Per-cycle observation tallies, cleared at the start of each scenario.
    int hs_cnt, vs_cnt, ad_cnt, nf_cnt, nf_bad, win_bad, link_bad;
    int inv_bad, idle_bad, run_low, disc, fc_bad;
    int exp_fc = 0;
    int prev_h = 0, prev_v = 0;
    logic prev_run = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic clear_stats();
        hs_cnt = 0; vs_cnt = 0; ad_cnt = 0; nf_cnt = 0; nf_bad = 0;
        win_bad = 0; link_bad = 0; inv_bad = 0; idle_bad = 0;
        run_low = 0; disc = 0; fc_bad = 0;
    endtask

    // Observe one cycle of both instances against the raster definition.
    task automatic sample();
        int h, v, hn, vn, nh, nv;
        logic in_hs, in_vs, in_ad, in_hs_n, in_vs_n;
        h  = int'(hc);   v  = int'(vc);
        hn = int'(hc_n); vn = int'(vc_n);
        in_hs   = run && h >= 10 && h <= 12;
        in_vs   = run && v >= 7 && v <= 8;
        in_ad   = run && h < 8 && v < 6;
        in_hs_n = run_n && hn >= 10 && hn <= 12;
        in_vs_n = run_n && vn >= 7 && vn <= 8;
        if (hs === 1'b1) hs_cnt++;
        if (vs === 1'b1) vs_cnt++;
        if (ad === 1'b1) ad_cnt++;
        if (nf === 1'b1) begin
            nf_cnt++;
            if (!(h == 0 && v == 6)) nf_bad++;
            exp_fc = (exp_fc == 59) ? 0 : exp_fc + 1;
        end
        if (int'(fc) != exp_fc || $isunknown(fc)) fc_bad++;
        if (hs !== in_hs || vs !== in_vs || ad !== in_ad) win_bad++;
        if (ctrl !== {vs, hs} || ve !== ad) link_bad++;
        if (hs_n !== ~in_hs_n || vs_n !== ~in_vs_n || ctrl_n !== {vs_n, hs_n}) inv_bad++;
        if (run !== 1'b1) begin
            run_low++;
            if (h != 0 || v != 0) idle_bad++;
        end
        if (run === 1'b1 && prev_run) begin
            nh = (prev_h == 15) ? 0 : prev_h + 1;
            nv = (prev_h == 15) ? ((prev_v == 9) ? 0 : prev_v + 1) : prev_v;
            if (h != nh || v != nv) disc++;
        end
        prev_h = h; prev_v = v; prev_run = (run === 1'b1);
    endtask

    task automatic step();
        logic rst_was;
        rst_was = rst;
        @(posedge clk);
        #1;
        if (rst_was) exp_fc = 0;
        sample();
    endtask

    task automatic goto_pos(input int th, input int tv);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (int'(hc) == th && int'(vc) == tv) begin
                hit = 1'b1;
                break;
            end
            step();
        end
        chk("goto_reach", 32'(hit), 32'd1);
    endtask

    initial begin
        clear_stats();

        // Reset state.
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_h", 32'(hc), 0);
        chk("rst_v", 32'(vc), 0);
        chk("rst_ad", 32'(ad), 0);
        chk("rst_ve", 32'(ve), 0);
        chk("rst_nf", 32'(nf), 0);
        chk("rst_fc", 32'(fc), 0);
        chk("rst_running", 32'(run), 0);
        chk("rst_hs", 32'(hs), 0);
        chk("rst_vs", 32'(vs), 0);
        chk("rst_ctrl", 32'(ctrl), 0);
        chk("rst_hs_neg", 32'(hs_n), 1);
        chk("rst_vs_neg", 32'(vs_n), 1);
        chk("rst_ctrl_neg", 32'(ctrl_n), 3);

        // One-cycle enable: first pixel next cycle, drain to frame end.
        clear_stats();
        en = 1'b1;
        step();
        chk("start_h", 32'(hc), 0);
        chk("start_v", 32'(vc), 0);
        chk("start_ad", 32'(ad), 1);
        chk("start_running", 32'(run), 1);
        en = 1'b0;
        repeat (159) step();
        chk("drain_last_h", 32'(hc), 15);
        chk("drain_last_v", 32'(vc), 9);
        chk("drain_running", 32'(run_low), 0);
        step();
        chk("stop_h", 32'(hc), 0);
        chk("stop_v", 32'(vc), 0);
        chk("stop_ad", 32'(ad), 0);
        chk("stop_running", 32'(run), 0);
        chk("drain_nf_count", 32'(nf_cnt), 1);
        chk("drain_fc", 32'(fc), 1);
        chk("drain_disc", 32'(disc), 0);
        step();
        chk("idle_hold_h", 32'(hc), 0);
        chk("idle_hold_running", 32'(run), 0);

        // Two continuous frames.
        clear_stats();
        en = 1'b1;
        repeat (320) step();
        chk("hs_cycles", 32'(hs_cnt), 60);
        chk("vs_cycles", 32'(vs_cnt), 64);
        chk("ad_cycles", 32'(ad_cnt), 96);
        chk("nf_count", 32'(nf_cnt), 2);
        chk("nf_position", 32'(nf_bad), 0);
        chk("fc_after_2", 32'(fc), 3);
        chk("window_errs", 32'(win_bad), 0);
        chk("link_errs", 32'(link_bad), 0);
        chk("neg_pol_errs", 32'(inv_bad), 0);
        chk("run_disc", 32'(disc), 0);

        // Enable drops mid-frame and returns before frame end.
        goto_pos(5, 3);
        en = 1'b0;
        clear_stats();
        goto_pos(0, 5);
        chk("mid_drain_running", 32'(run), 1);
        en = 1'b1;
        goto_pos(15, 9);
        step();
        chk("resume_h", 32'(hc), 0);
        chk("resume_v", 32'(vc), 0);
        chk("resume_ad", 32'(ad), 1);
        chk("resume_run_low", 32'(run_low), 0);
        chk("resume_disc", 32'(disc), 0);

        // Enable drops exactly on the last pixel while running.
        goto_pos(15, 9);
        en = 1'b0;
        step();
        chk("edge_stop_running", 32'(run), 0);
        chk("edge_stop_ad", 32'(ad), 0);
        chk("edge_stop_h", 32'(hc), 0);
        step();
        chk("edge_idle_running", 32'(run), 0);

        // Reset mid-frame with enable held high.
        en = 1'b1;
        goto_pos(10, 4);
        rst = 1'b1;
        step();
        chk("mrst_h", 32'(hc), 0);
        chk("mrst_v", 32'(vc), 0);
        chk("mrst_ad", 32'(ad), 0);
        chk("mrst_nf", 32'(nf), 0);
        chk("mrst_fc", 32'(fc), 0);
        chk("mrst_running", 32'(run), 0);
        chk("mrst_ctrl", 32'(ctrl), 0);
        chk("mrst_ctrl_neg", 32'(ctrl_n), 3);
        rst = 1'b0;
        step();
        chk("restart_h", 32'(hc), 0);
        chk("restart_v", 32'(vc), 0);
        chk("restart_ad", 32'(ad), 1);
        chk("restart_running", 32'(run), 1);

        // Sixty frames: frame counter wraps on the 60th pulse.
        clear_stats();
        repeat (59 * 160) step();
        chk("fc_59", 32'(fc), 59);
        chk("nf_59", 32'(nf_cnt), 59);
        repeat (160) step();
        chk("fc_wrap", 32'(fc), 0);
        chk("nf_60", 32'(nf_cnt), 60);
        chk("fc_track", 32'(fc_bad), 0);
        chk("long_link_errs", 32'(link_bad), 0);
        chk("long_window_errs", 32'(win_bad), 0);
        chk("long_neg_pol_errs", 32'(inv_bad), 0);
        chk("long_disc", 32'(disc), 0);
        chk("long_idle", 32'(idle_bad), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
